cpu_seq: RTL and testbench

CPU_SEQ -- requirements
Module: cpu_seq

---
 rtl/cpu_seq.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB).
// Drives the memory handshakes and the IR, register-file and PC write strobes
// from decoder flags.
// Optional feature macro: CPU_SEQ_PERF_EN builds the retired-instruction and
// cycle counters. When the macro is undefined, both counter ports are tied to 0
// and no counter flops are built.
module cpu_seq #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             r_mem_en,
  input  logic             w_mem_en,
  input  logic             reg_en,
  input  logic             jce,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] S_FETCH  = ST_W'(0);
  localparam logic [ST_W-1:0] S_DECODE = ST_W'(1);
  localparam logic [ST_W-1:0] S_EXEC   = ST_W'(2);
  localparam logic [ST_W-1:0] S_MEM    = ST_W'(3);
  localparam logic [ST_W-1:0] S_WB     = ST_W'(4);

  // Memory operation captured as EXEC is left. A store wins when both flags are set.
  typedef struct packed {
    logic store;
    logic load;
  } mem_op_t;

  logic [ST_W-1:0] state_q, state_d;
  logic            imem_req_q, imem_req_d;
  mem_op_t         op_q, op_d;
  logic            exec_mem;

  assign exec_mem = w_mem_en | r_mem_en;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (imem_req_q && imem_ack) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (exec_mem) begin
          state_d = S_MEM;
        end else if (reg_en) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (op_q.store) begin
            state_d = S_FETCH;
          end else if (op_q.load) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Output decode. PC update and IR load fire in the cycle their ack or decision arrives.
  always_comb begin
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we = imem_req_q & imem_ack;
      end
      S_EXEC: begin
        if (!exec_mem && !reg_en) begin
          pc_we  = 1'b1;
          pc_sel = jce;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = op_q.store;
        if (dmem_ack && op_q.store) begin
          pc_we  = 1'b1;
          pc_sel = jce;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        pc_sel = jce;
      end
      default: begin
        ir_we = 1'b0;
      end
    endcase
  end

  // Fetch request: armed on the edge that enters FETCH (if running), held until ack.
  always_comb begin
    imem_req_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_req_q) begin
          imem_req_d = ~imem_ack;
        end else begin
          imem_req_d = run;
        end
      end
      S_EXEC, S_MEM, S_WB: begin
        imem_req_d = (state_d == S_FETCH) & run;
      end
      default: imem_req_d = 1'b0;
    endcase
  end

  // Memory operation captured on the EXEC cycle.
  always_comb begin
    op_d = op_q;
    if (state_q == S_EXEC) begin
      op_d.store = w_mem_en;
      op_d.load  = r_mem_en & ~w_mem_en;
    end
  end

  // Fetch request and memory-op registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_req_q <= 1'b0;
      op_q       <= '0;
    end else begin
      imem_req_q <= imem_req_d;
      op_q       <= op_d;
    end
  end

  assign imem_req = imem_req_q;
  assign state    = state_q;

`ifdef CPU_SEQ_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  // Counter increments. Both counters wrap naturally at 2^CNT_W.
  always_comb begin
    cycle_cnt_d  = cycle_cnt_q + CNT_W'(1);
    retire_cnt_d = retire_cnt_q;
    if (pc_we) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;
`else
  assign cycle_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: directed and randomized instruction streams against a trace
// model built from the sequencer's per-phase behaviour and latency rules.
module tb_cpu_seq;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MOD = 1 << CNT_W;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam int BR   = 0;
  localparam int ALU  = 1;
  localparam int LD   = 2;
  localparam int ST   = 3;
  localparam int BOTH = 4;

  logic clk = 1'b0;
  logic rst, run, imem_ack, dmem_ack, r_mem_en, w_mem_en, reg_en, jce;
  logic imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel;
  logic [2:0] state;
  logic [CNT_W-1:0] retire_cnt, cycle_cnt;

  int checks   = 0;
  int failures = 0;
  int unsigned exp_cyc = 0;
  int unsigned exp_ret = 0;

  always #5 clk = ~clk;

  cpu_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .r_mem_en(r_mem_en), .w_mem_en(w_mem_en), .reg_en(reg_en), .jce(jce),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel), .state(state),
    .retire_cnt(retire_cnt), .cycle_cnt(cycle_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input logic [2:0] st, input logic ireq, input logic irw,
                             input logic dreq, input logic dwe, input logic rwe,
                             input logic pwe, input logic jce_v, input string ph);
    check({ph, " state"}, 32'(state), 32'(st));
    check({ph, " strobes"},
          {25'd0, imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel},
          {25'd0, ireq, irw, dreq, dwe, rwe, pwe, pwe & jce_v});
`ifdef CPU_SEQ_PERF_EN
    check({ph, " cycle_cnt"}, 32'(cycle_cnt), 32'(exp_cyc % CNT_MOD));
    check({ph, " retire_cnt"}, 32'(retire_cnt), 32'(exp_ret % CNT_MOD));
`else
    check({ph, " cycle_cnt"}, 32'(cycle_cnt), 32'd0);
    check({ph, " retire_cnt"}, 32'(retire_cnt), 32'd0);
`endif
  endtask

  // One clock cycle: drive at negedge, check shortly after, then advance the model at posedge.
  task automatic step(input logic r, input logic ia, input logic da, input logic rm,
                      input logic wm, input logic re, input logic [2:0] st,
                      input logic ireq, input logic irw, input logic dreq, input logic dwe,
                      input logic rwe, input logic pwe, input string ph);
    logic j;
    @(negedge clk);
    j = 1'($urandom);
    run = r; imem_ack = ia; dmem_ack = da;
    r_mem_en = rm; w_mem_en = wm; reg_en = re; jce = j;
    #1;
    check_cycle(st, ireq, irw, dreq, dwe, rwe, pwe, j, ph);
    @(posedge clk);
    exp_cyc++;
    if (pwe) exp_ret++;
  endtask

  // Expected trace: FETCH x(1+di), DECODE, EXEC, [MEM x(1+dd)], [WB].
  task automatic run_instr(input int cls, input int di, input int dd, input logic r,
                           input string nm);
    logic rm, wm, re, mem, wb;
    rm  = (cls == LD) || (cls == BOTH);
    wm  = (cls == ST) || (cls == BOTH);
    re  = (cls == ALU) ? 1'b1 : (cls == BR) ? 1'b0 : 1'($urandom);
    mem = rm | wm;
    wb  = (cls == ALU) || (cls == LD);
    for (int j = 0; j <= di; j++)
      step(r, (j == di), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           S_FETCH, 1'b1, (j == di), 1'b0, 1'b0, 1'b0, 1'b0, {nm, " fetch"});
    step(r, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
         S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {nm, " decode"});
    step(r, 1'($urandom), 1'($urandom), rm, wm, re,
         S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !mem && !re, {nm, " exec"});
    if (mem) begin
      for (int j = 0; j <= dd; j++)
        step(r, 1'($urandom), (j == dd), 1'($urandom), 1'($urandom), 1'($urandom),
             S_MEM, 1'b0, 1'b0, 1'b1, wm, 1'b0, wm && (j == dd), {nm, " mem"});
    end
    if (wb)
      step(r, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           S_WB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {nm, " wb"});
  endtask

  // Stopped in FETCH with no request pending; stray imem_ack must be ignored.
  task automatic idle(input int n, input logic r_last);
    for (int i = 0; i < n; i++)
      step((i == n - 1) ? r_last : 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0,
           S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    r_mem_en = 1'b0; w_mem_en = 1'b0; reg_en = 1'b0; jce = 1'b0;
    exp_cyc = 0; exp_ret = 0;
    #1;
    check_cycle(S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "in_reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    do_reset();
    // First request appears only after an edge with run=1.
    idle(2, 1'b1);

    run_instr(ALU,  0, 0, 1'b1, "alu_add");
    run_instr(LD,   0, 3, 1'b1, "lw_delay3");
    run_instr(BR,   0, 0, 1'b1, "beq");
    run_instr(BOTH, 0, 1, 1'b1, "ld_st_both");
    run_instr(ST,   1, 0, 1'b1, "sw");
    // run dropped while the request waits on a delayed ack.
    run_instr(ALU,  2, 0, 1'b0, "run_drop");
    idle(3, 1'b1);

    for (int n = 0; n < 40; n++)
      run_instr($urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1,
                "rand");

    // Counter wrap: 20 ALU instructions from a fresh reset.
    do_reset();
    idle(1, 1'b1);
    for (int n = 0; n < 20; n++)
      run_instr(ALU, $urandom_range(0, 1), 0, 1'b1, "alu20");

    // Reset asserted in the middle of a data access.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_FETCH, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ab_fetch");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ab_dec");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ab_exec");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_MEM, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "ab_mem");
    @(negedge clk);
    jce = 1'b1;
    #1;
    check_cycle(S_MEM, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "ab_mem_wait");
    #2 rst = 1'b0;
    exp_cyc = 0; exp_ret = 0;
    #1;
    check_cycle(S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ab_async_rst");
    do_reset();
    idle(1, 1'b1);
    run_instr(LD, 0, 0, 1'b1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
